// File: rtl/rhythm_pkg.sv
// Shared rhythm-game definitions: judge FSM states and default timing
// constants also used by the chart sequencer.
package rhythm_pkg;

    localparam int CLK_HZ              = 50_000_000;
    // 10 ms of stable button level before it is accepted
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
    // 100 ms hit window after a note reaches the hit line
    localparam int WINDOW_CYCLES_DEF   = CLK_HZ / 10;
    localparam int COMBO_W_DEF         = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } judge_state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button conditioner: two-flop synchroniser, debounce counter and
// rising-edge detector producing a one-cycle press pulse.
module btn_conditioner
    import rhythm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            level_prev_q;
    logic            press_q;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state and registered 0->1 edge of the accepted level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/hit_judge.sv
// One-lane hit judge: opens a timing window on each note, emits a hit or
// miss pulse per note and tracks current and best combo.
module hit_judge
    import rhythm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int WINDOW_CYCLES   = WINDOW_CYCLES_DEF,
    parameter int COMBO_W         = COMBO_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn,
    input  logic               enable,
    input  logic               note_due,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               window_open,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]   WIN_LOAD  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    logic               press;
    judge_state_e       state_q, state_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic               hit_d, miss_d;
    logic               hit_q, miss_q, open_q;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [COMBO_W-1:0] max_q, max_d;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn),
        .press_o(press)
    );

    // Judge FSM: a press wins over both expiry and a new note; a new note
    // while open judges the pending one and restarts the window
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        if (!enable) begin
            // Open window is dropped silently while the song is paused
            state_d   = ST_IDLE;
            win_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (note_due) begin
                        state_d   = ST_OPEN;
                        win_cnt_d = WIN_LOAD;
                    end
                end
                ST_OPEN: begin
                    if (press) begin
                        hit_d = 1'b1;
                        if (note_due) begin
                            win_cnt_d = WIN_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (note_due) begin
                        miss_d    = 1'b1;
                        win_cnt_d = WIN_LOAD;
                    end else if (win_cnt_q == '0) begin
                        miss_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        win_cnt_d = win_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Combo follows the judgement of this cycle; best combo tracks its peak
    always_comb begin
        combo_d = combo_q;
        if (hit_d) begin
            if (combo_q != COMBO_MAX) begin
                combo_d = combo_q + 1'b1;
            end
        end else if (miss_d) begin
            combo_d = '0;
        end
        max_d = (combo_d > max_q) ? combo_d : max_q;
    end

    // State, window counter, pulses and combo registers; window_open is taken
    // from the state register so it stays high through the pulse cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            open_q    <= 1'b0;
            combo_q   <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            open_q    <= (state_q == ST_OPEN);
            combo_q   <= combo_d;
            max_q     <= max_d;
        end
    end

    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign window_open = open_q;
    assign combo       = combo_q;
    assign max_combo   = max_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with DEBOUNCE_CYCLES=4, WINDOW_CYCLES=10,
// COMBO_W=3. Edge numbers in comments are relative to each scenario; a
// value "after edge e" is sampled 1 time unit past that rising edge.
module tb_hit_judge;
    import rhythm_pkg::*;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       enable;
    logic       note_due;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       window_open;
    logic [2:0] combo;
    logic [2:0] max_combo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hit_judge #(
        .DEBOUNCE_CYCLES(4),
        .WINDOW_CYCLES  (10),
        .COMBO_W        (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .enable     (enable),
        .note_due   (note_due),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .window_open(window_open),
        .combo      (combo),
        .max_combo  (max_combo)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // hold btn so the press lands after edge 5, note sampled at edge 0;
    // returns just after edge 6 where the hit pulse is registered
    task automatic do_hit();
        btn = 1'b1;
        step();
        note_due = 1'b1;
        step();
        note_due = 1'b0;
        repeat (6) step();
    endtask

    // release the button and let the accepted level fall back to 0
    task automatic release_btn();
        btn = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset();
        rst = 1'b0; btn = 1'b0; enable = 1'b1; note_due = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || window_open !== 1'b0) begin
            $display("FAIL reset_pulses: got hit=%b miss=%b open=%b required 0 0 0",
                     hit_pulse, miss_pulse, window_open);
        end else pass_cnt++;
        total_cnt++;
        if (combo !== 3'd0 || max_combo !== 3'd0) begin
            $display("FAIL reset_combo: got combo=%0d max=%0d required 0 0", combo, max_combo);
        end else pass_cnt++;
        rst = 1'b1;
    endtask

    // btn sampled high from edge 20 -> press after edge 26; 3-cycle glitch -> none
    task automatic test_conditioner();
        logic exp_p;
        for (int e = 0; e <= 30; e++) begin
            btn = (e >= 20);
            step();
            exp_p = (e == 26);
            total_cnt++;
            if (dut.u_cond.press_o !== exp_p) begin
                $display("FAIL press e=%0d: got %b required %b", e, dut.u_cond.press_o, exp_p);
            end else pass_cnt++;
            total_cnt++;
            if (hit_pulse !== 1'b0) begin
                $display("FAIL idle_press_ignored e=%0d: got hit=%b required 0", e, hit_pulse);
            end else pass_cnt++;
        end
        release_btn();
        for (int e = 0; e <= 12; e++) begin
            btn = (e >= 2 && e <= 4);
            step();
            total_cnt++;
            if (dut.u_cond.press_o !== 1'b0) begin
                $display("FAIL glitch_press e=%0d: got %b required 0", e, dut.u_cond.press_o);
            end else pass_cnt++;
        end
        btn = 1'b0;
    endtask

    // note at edge 0, press after edge 5 -> hit after edge 6
    task automatic test_hit();
        logic exp_h, exp_o, exp_p;
        btn = 1'b1;
        step();
        note_due = 1'b1;
        step();
        note_due = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_h = (e == 6);
            exp_o = (e <= 6);
            exp_p = (e == 5);
            total_cnt++;
            if (hit_pulse !== exp_h || miss_pulse !== 1'b0) begin
                $display("FAIL hit e=%0d: got hit=%b miss=%b required %b 0", e, hit_pulse, miss_pulse, exp_h);
            end else pass_cnt++;
            total_cnt++;
            if (window_open !== exp_o) begin
                $display("FAIL hit_open e=%0d: got %b required %b", e, window_open, exp_o);
            end else pass_cnt++;
            total_cnt++;
            if (dut.u_cond.press_o !== exp_p) begin
                $display("FAIL hit_press e=%0d: got %b required %b", e, dut.u_cond.press_o, exp_p);
            end else pass_cnt++;
        end
        total_cnt++;
        if (combo !== 3'd1 || max_combo !== 3'd1) begin
            $display("FAIL hit_combo: got combo=%0d max=%0d required 1 1", combo, max_combo);
        end else pass_cnt++;
        release_btn();
    endtask

    // note at edge 0, no press -> miss after edge 10, window_open 1..10
    task automatic test_miss();
        logic exp_m, exp_o;
        note_due = 1'b1;
        step();
        note_due = 1'b0;
        total_cnt++;
        if (window_open !== 1'b0) begin
            $display("FAIL miss_open e=0: got %b required 0", window_open);
        end else pass_cnt++;
        for (int e = 1; e <= 11; e++) begin
            step();
            exp_m = (e == 10);
            exp_o = (e <= 10);
            total_cnt++;
            if (miss_pulse !== exp_m || hit_pulse !== 1'b0) begin
                $display("FAIL miss e=%0d: got miss=%b hit=%b required %b 0", e, miss_pulse, hit_pulse, exp_m);
            end else pass_cnt++;
            total_cnt++;
            if (window_open !== exp_o) begin
                $display("FAIL miss_open e=%0d: got %b required %b", e, window_open, exp_o);
            end else pass_cnt++;
        end
        total_cnt++;
        if (combo !== 3'd0 || max_combo !== 3'd1) begin
            $display("FAIL miss_combo: got combo=%0d max=%0d required 0 1", combo, max_combo);
        end else pass_cnt++;
    endtask

    // nine hits saturate combo at 7, then a miss clears combo but not best
    task automatic test_combo();
        logic [2:0] exp_c, exp_mx;
        for (int i = 1; i <= 9; i++) begin
            do_hit();
            exp_c  = (i > 7) ? 3'd7 : 3'(i);
            exp_mx = (exp_c > 3'd1) ? exp_c : 3'd1;
            total_cnt++;
            if (hit_pulse !== 1'b1 || combo !== exp_c || max_combo !== exp_mx) begin
                $display("FAIL combo hit %0d: got hit=%b combo=%0d max=%0d required 1 %0d %0d",
                         i, hit_pulse, combo, max_combo, exp_c, exp_mx);
            end else pass_cnt++;
            release_btn();
        end
        note_due = 1'b1;
        step();
        note_due = 1'b0;
        repeat (10) step();
        total_cnt++;
        if (miss_pulse !== 1'b1 || combo !== 3'd0 || max_combo !== 3'd7) begin
            $display("FAIL combo_miss: got miss=%b combo=%0d max=%0d required 1 0 7",
                     miss_pulse, combo, max_combo);
        end else pass_cnt++;
    endtask

    // second note coincident with a press, then second note with no press
    task automatic test_overlap();
        logic exp_h, exp_m, exp_o;
        for (int e = -3; e <= 15; e++) begin
            btn      = (e <= 4);
            note_due = (e == 0 || e == 4);
            step();
            exp_h = (e == 4);
            exp_m = (e == 14);
            exp_o = (e >= 1 && e <= 14);
            total_cnt++;
            if (hit_pulse !== exp_h || miss_pulse !== exp_m) begin
                $display("FAIL overlap_press e=%0d: got hit=%b miss=%b required %b %b",
                         e, hit_pulse, miss_pulse, exp_h, exp_m);
            end else pass_cnt++;
            total_cnt++;
            if (window_open !== exp_o) begin
                $display("FAIL overlap_press_open e=%0d: got %b required %b", e, window_open, exp_o);
            end else pass_cnt++;
            if (e == 4) begin
                total_cnt++;
                if (combo !== 3'd1) begin
                    $display("FAIL overlap_combo: got %0d required 1", combo);
                end else pass_cnt++;
            end
        end
        btn = 1'b0;
        note_due = 1'b0;
        for (int e = 0; e <= 14; e++) begin
            note_due = (e == 0 || e == 3);
            step();
            exp_m = (e == 3 || e == 13);
            exp_o = (e >= 1 && e <= 13);
            total_cnt++;
            if (miss_pulse !== exp_m || hit_pulse !== 1'b0) begin
                $display("FAIL overlap_nopress e=%0d: got miss=%b hit=%b required %b 0",
                         e, miss_pulse, hit_pulse, exp_m);
            end else pass_cnt++;
            total_cnt++;
            if (window_open !== exp_o) begin
                $display("FAIL overlap_nopress_open e=%0d: got %b required %b", e, window_open, exp_o);
            end else pass_cnt++;
        end
        note_due = 1'b0;
        total_cnt++;
        if (combo !== 3'd0 || max_combo !== 3'd7) begin
            $display("FAIL overlap_end_combo: got combo=%0d max=%0d required 0 7", combo, max_combo);
        end else pass_cnt++;
    endtask

    // enable dropped at edge 3 discards the window silently; combo is held
    task automatic test_enable();
        logic exp_o;
        do_hit();
        total_cnt++;
        if (combo !== 3'd1) begin
            $display("FAIL enable_pre_combo: got %0d required 1", combo);
        end else pass_cnt++;
        release_btn();
        for (int e = 0; e <= 12; e++) begin
            note_due = (e == 0 || e == 6);
            enable   = (e < 3);
            step();
            exp_o = (e >= 1 && e <= 3);
            total_cnt++;
            if (miss_pulse !== 1'b0 || hit_pulse !== 1'b0) begin
                $display("FAIL enable_pulse e=%0d: got miss=%b hit=%b required 0 0", e, miss_pulse, hit_pulse);
            end else pass_cnt++;
            total_cnt++;
            if (window_open !== exp_o) begin
                $display("FAIL enable_open e=%0d: got %b required %b", e, window_open, exp_o);
            end else pass_cnt++;
            if (e == 3) begin
                total_cnt++;
                if (dut.state_q !== ST_IDLE) begin
                    $display("FAIL enable_state: got %0d required %0d", dut.state_q, ST_IDLE);
                end else pass_cnt++;
            end
        end
        note_due = 1'b0;
        enable   = 1'b1;
        total_cnt++;
        if (combo !== 3'd1 || max_combo !== 3'd7) begin
            $display("FAIL enable_combo: got combo=%0d max=%0d required 1 7", combo, max_combo);
        end else pass_cnt++;
    endtask

    // asynchronous reset in the middle of an open window
    task automatic test_reset_mid();
        note_due = 1'b1;
        step();
        note_due = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (window_open !== 1'b1) begin
            $display("FAIL rst_mid_pre_open: got %b required 1", window_open);
        end else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (window_open !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 ||
            combo !== 3'd0 || max_combo !== 3'd0) begin
            $display("FAIL rst_mid_async: got open=%b hit=%b miss=%b combo=%0d max=%0d required all 0",
                     window_open, hit_pulse, miss_pulse, combo, max_combo);
        end else pass_cnt++;
        repeat (2) step();
        rst = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            total_cnt++;
            if (window_open !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
                $display("FAIL rst_mid_after e=%0d: got open=%b hit=%b miss=%b required 0 0 0",
                         e, window_open, hit_pulse, miss_pulse);
            end else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_conditioner();
        test_hit();
        test_miss();
        test_combo();
        test_overlap();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
